// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default constants for the fetch-stage sequencing controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_HOLD   = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [15:0] PC_INC_DEF    = 16'h0002;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch controller, instruction memory, execute/hazard logic and IF/ID.
interface fetch_ctrl_if;
  // imem_en is a request: imem_addr stays stable while imem_en=1 until a cycle with imem_done=1,
  // which may be the request cycle itself; imem_rdata is only meaningful in that cycle.
  // if_valid qualifies if_instr/if_pc_next every cycle; if_instr reads NOP when if_valid=0.
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic [15:0] pc_curr;
  logic        halted;

  modport master (
    input  redirect_valid, redirect_pc, stall, halt, imem_done, imem_rdata,
    output imem_en, imem_addr, if_valid, if_instr, if_pc_next, pc_curr, halted
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, halt, imem_done, imem_rdata,
    input  imem_en, imem_addr, if_valid, if_instr, if_pc_next, pc_curr, halted
  );
endinterface

// File: rtl/cla_16b.sv
// 16-bit adder built from per-bit generate/propagate terms; carry-out is not needed by its users.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);
  always_comb begin : add_chain
    logic carry;
    carry = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry);
    end
  end
endmodule

// File: rtl/fetch_hold_buf.sv
// One-entry instruction+PC buffer that keeps a stalled fetch result alive while IF/ID is held.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues instruction-memory requests and feeds IF/ID,
// handling memory wait states, hazard stalls, execute redirects and halt.
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [15:0] PC_INC    = PC_INC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus,
  output fetch_state_e dbg_state
);
  fetch_state_e state, state_d;
  logic [15:0]  pc, pc_d, pend_pc, pend_pc_d, pc_inc, add_a;
  logic         pend_valid, pend_valid_d;
  logic         buf_load, buf_flush, buf_valid;
  logic [15:0]  buf_instr, buf_pc;
  logic         valid_raw;
  logic [15:0]  instr_raw;

  fetch_hold_buf u_hold (
    .clk(clk), .rst(rst), .load(buf_load), .flush(buf_flush),
    .instr_in(bus.imem_rdata), .pc_in(pc),
    .valid(buf_valid), .instr(buf_instr), .pc(buf_pc)
  );

  // One adder serves both the next sequential PC and if_pc_next of a buffered instruction.
  assign add_a = buf_valid ? buf_pc : pc;

  cla_16b u_pc_add (.a(add_a), .b(PC_INC), .cin(1'b0), .sum(pc_inc));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      pend_valid <= pend_valid_d;
      pend_pc    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    pend_valid_d = pend_valid;
    pend_pc_d    = pend_pc;
    buf_load     = 1'b0;
    buf_flush    = 1'b0;
    valid_raw    = 1'b0;
    instr_raw    = bus.imem_rdata;
    case (state)
      ST_FETCH: begin
        if (bus.imem_done) begin
          if (bus.halt) begin
            state_d = ST_HALTED;
          end else if (bus.redirect_valid || pend_valid) begin
            // Returned word belongs to the wrong path; a same-cycle redirect beats the pending one.
            pc_d         = bus.redirect_valid ? bus.redirect_pc : pend_pc;
            pend_valid_d = 1'b0;
          end else begin
            valid_raw = 1'b1;
            pc_d      = pc_inc;
            if (bus.stall) begin
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end
          end
        end else if (bus.halt) begin
          state_d = ST_HALTED;
        end else if (bus.redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = bus.redirect_pc;
        end
      end
      ST_HOLD: begin
        instr_raw = buf_instr;
        if (bus.halt) begin
          buf_flush = 1'b1;
          state_d   = ST_HALTED;
        end else if (bus.redirect_valid) begin
          buf_flush = 1'b1;
          pc_d      = bus.redirect_pc;
          state_d   = ST_FETCH;
        end else begin
          valid_raw = 1'b1;
          if (!bus.stall) begin
            buf_flush = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  assign bus.imem_en    = rst && (state == ST_FETCH);
  assign bus.imem_addr  = pc;
  assign bus.if_valid   = rst && valid_raw;
  assign bus.if_instr   = bus.if_valid ? instr_raw : NOP_INSTR;
  assign bus.if_pc_next = pc_inc;
  assign bus.pc_curr    = pc;
  assign bus.halted     = (state == ST_HALTED);
  assign dbg_state      = state;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [15:0] INC = 16'h0002;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();
  fetch_state_e dbg_state;

  fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Model: fetch PC, pending redirect target (0 or 1 entries), held instruction (0 or 1 entries), stopped flag.
  typedef struct packed { logic [15:0] instr; logic [15:0] pc; } held_t;
  logic [15:0] m_pc;
  logic [15:0] pend_q[$];
  held_t       held_q[$];
  bit          stopped;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", name, cycle, got, exp);
    end
  endtask

  task automatic set_in(input bit done, input bit rv, input logic [15:0] rp,
                        input bit st, input bit hl, input logic [15:0] rd);
    bus.imem_done      = done;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.stall          = st;
    bus.halt           = hl;
    bus.imem_rdata     = rd;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    pend_q.delete();
    held_q.delete();
    stopped = 0;
  endtask

  // Compares every output against the model for the current inputs, then advances the model.
  task automatic check_model();
    logic        exp_en, exp_valid;
    logic [15:0] exp_instr, exp_pcn;
    logic [1:0]  exp_state;
    held_t       h;
    exp_en = 1'b0; exp_valid = 1'b0; exp_instr = NOP; exp_pcn = '0;
    exp_state = stopped ? 2'b10 : ((held_q.size() != 0) ? 2'b01 : 2'b00);
    chk("pc_curr", bus.pc_curr, m_pc);
    chk("dbg_state", 16'(dbg_state), 16'(exp_state));
    chk("halted", 16'(bus.halted), 16'(stopped));
    if (stopped) begin
      // frozen until reset
    end else if (held_q.size() != 0) begin
      if (bus.halt) begin
        stopped = 1; held_q.delete();
      end else if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc; held_q.delete();
      end else begin
        exp_valid = 1'b1; exp_instr = held_q[0].instr; exp_pcn = held_q[0].pc + INC;
        if (!bus.stall) held_q.delete();
      end
    end else begin
      exp_en = 1'b1;
      chk("imem_addr", bus.imem_addr, m_pc);
      if (bus.imem_done) begin
        if (bus.halt) begin
          stopped = 1;
        end else if (bus.redirect_valid || pend_q.size() != 0) begin
          m_pc = bus.redirect_valid ? bus.redirect_pc : pend_q[0];
          pend_q.delete();
        end else begin
          exp_valid = 1'b1; exp_instr = bus.imem_rdata; exp_pcn = m_pc + INC;
          if (bus.stall) begin
            h.instr = bus.imem_rdata; h.pc = m_pc;
            held_q.push_back(h);
          end
          m_pc = m_pc + INC;
        end
      end else if (bus.halt) begin
        stopped = 1;
      end else if (bus.redirect_valid) begin
        pend_q.delete();
        pend_q.push_back(bus.redirect_pc);
      end
    end
    chk("imem_en", 16'(bus.imem_en), 16'(exp_en));
    chk("if_valid", 16'(bus.if_valid), 16'(exp_valid));
    chk("if_instr", bus.if_instr, exp_instr);
    if (exp_valid) chk("if_pc_next", bus.if_pc_next, exp_pcn);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    check_model();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic step();
    sample();
    finish_cycle();
  endtask

  task automatic lit_reset_state(input string tag);
    chk({tag, "_en"}, 16'(bus.imem_en), 16'h0);
    chk({tag, "_valid"}, 16'(bus.if_valid), 16'h0);
    chk({tag, "_instr"}, bus.if_instr, NOP);
    chk({tag, "_halted"}, 16'(bus.halted), 16'h0);
    chk({tag, "_pc"}, bus.pc_curr, 16'h0000);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    set_in(1, 1, 16'h1234, 0, 0, 16'hBEEF);
    sample();
    lit_reset_state("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=running exp=finished", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;

    // Zero-wait memory, no hazards.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 0, 0, 16'($urandom));
      sample();
      chk("zw_pc", bus.pc_curr, 16'(2 * i));
      chk("zw_pcn", bus.if_pc_next, 16'(2 * (i + 1)));
      chk("zw_valid", 16'(bus.if_valid), 16'h1);
      finish_cycle();
    end

    // Memory waits 3 cycles at 0004, then a redirect to 0040 before a delayed return.
    do_reset();
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 0, 0, 0, 16'($urandom)); step(); end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 16'($urandom));
      sample();
      chk("wait_addr", bus.imem_addr, 16'h0004);
      chk("wait_valid", 16'(bus.if_valid), 16'h0);
      finish_cycle();
    end
    set_in(1, 0, 0, 0, 0, 16'h1111);
    sample();
    chk("wait_pcn", bus.if_pc_next, 16'h0006);
    chk("wait_instr", bus.if_instr, 16'h1111);
    finish_cycle();
    set_in(0, 1, 16'h0040, 0, 0, 16'($urandom));
    step();
    set_in(1, 0, 0, 0, 0, 16'h2222);
    sample();
    chk("redir_discard", 16'(bus.if_valid), 16'h0);
    finish_cycle();
    set_in(1, 0, 0, 0, 0, 16'h3333);
    sample();
    chk("redir_addr", bus.imem_addr, 16'h0040);
    finish_cycle();

    // Stall for two cycles as 4123 returns at 0008, then redirect+stall while holding.
    do_reset();
    for (int i = 0; i < 4; i++) begin set_in(1, 0, 0, 0, 0, 16'($urandom)); step(); end
    set_in(1, 0, 0, 1, 0, 16'h4123);
    sample();
    chk("stall_addr", bus.imem_addr, 16'h0008);
    chk("stall_instr0", bus.if_instr, 16'h4123);
    finish_cycle();
    set_in(0, 0, 0, 1, 0, 16'($urandom));
    sample();
    chk("stall_instr1", bus.if_instr, 16'h4123);
    chk("stall_en1", 16'(bus.imem_en), 16'h0);
    finish_cycle();
    set_in(1, 0, 0, 0, 0, 16'($urandom));
    sample();
    chk("stall_instr2", bus.if_instr, 16'h4123);
    chk("stall_en2", 16'(bus.imem_en), 16'h0);
    finish_cycle();
    set_in(1, 0, 0, 1, 0, 16'h5555);
    sample();
    chk("stall_next", bus.imem_addr, 16'h000A);
    finish_cycle();
    set_in(0, 1, 16'h0123, 1, 0, 16'($urandom));
    sample();
    chk("hold_flush", 16'(bus.if_valid), 16'h0);
    finish_cycle();
    set_in(1, 1, 16'hFFFE, 0, 0, 16'($urandom));
    sample();
    chk("hold_redir", bus.imem_addr, 16'h0123);
    finish_cycle();

    // PC wrap at FFFE.
    set_in(1, 0, 0, 0, 0, 16'h6666);
    sample();
    chk("wrap_pcn", bus.if_pc_next, 16'h0000);
    finish_cycle();
    set_in(1, 0, 0, 0, 0, 16'h7777);
    sample();
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    finish_cycle();

    // Halt at 0010, stay frozen, then asynchronous reset mid-cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin set_in(1, 0, 0, 0, 0, 16'($urandom)); step(); end
    set_in(1, 0, 0, 0, 1, 16'($urandom));
    sample();
    chk("halt_pc", bus.pc_curr, 16'h0010);
    finish_cycle();
    for (int i = 0; i < 20; i++) begin
      set_in(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 0, 16'($urandom));
      sample();
      chk("halted_pc", bus.pc_curr, 16'h0010);
      chk("halted_en", 16'(bus.imem_en), 16'h0);
      chk("halted_flag", 16'(bus.halted), 16'h1);
      finish_cycle();
    end
    #3;
    rst = 1'b0;
    #1;
    lit_reset_state("async");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (stopped && $urandom_range(0, 4) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
               16'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 99) < 2, 16'($urandom));
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the fetch stage. Owns the PC register and drives instruction-memory requests.
- Handles multi-cycle instruction-memory handshakes, hazard stalls, branch/jump redirects from execute, and halt.
- Sits between the instruction memory and the IF/ID pipeline register, replacing the fixed PC+2 path with a controlled next-PC select.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, instruction word presented to decode when no valid instruction is available.
- PC_INC, 16'h0002, PC increment per sequential fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  execute stage requests a PC redirect (taken branch or jump).
- redirect_pc  input  16  redirect target address.
- stall  input  1  hazard unit holds IF/ID this cycle.
- halt  input  1  HALT has reached commit; stop fetching.
- imem_done  input  1  instruction memory returns data this cycle.
- imem_rdata  input  16  instruction memory read data; valid when imem_done=1.
- imem_en  output  1  instruction memory read request.
- imem_addr  output  16  instruction memory read address (= pc).
- if_valid  output  1  if_instr/if_pc_next hold a real instruction.
- if_instr  output  16  instruction to IF/ID; NOP_INSTR when if_valid=0.
- if_pc_next  output  16  PC of the delivered instruction + PC_INC.
- pc_curr  output  16  current fetch PC.
- halted  output  1  controller is in HALTED.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH, pend_valid=0, hold buffer empty.
  - if_valid=0, if_instr=NOP_INSTR, halted=0.
  - imem_en is forced to 0 while rst=0.
  - Reset mid-handshake abandons the request; the first request after release uses RESET_PC.
- States: FETCH, HOLD, HALTED.
- FETCH:
  - imem_en=1, imem_addr=pc.
  - imem_done may arrive in the same cycle as the request (zero-wait memory) or any later cycle; pc stays stable until done.
- FETCH, imem_done=1, evaluated in priority order:
  1. halt: discard data; state→HALTED.
  2. redirect_valid or pend_valid: discard data; if_valid=0; pc←redirect_pc (same-cycle redirect wins over the pending one), else pc←pend_pc; clear pend_valid; stay in FETCH.
  3. stall: capture imem_rdata and pc into the hold buffer; pc←pc+PC_INC; state→HOLD.
  4. Otherwise: if_valid=1, if_instr=imem_rdata, if_pc_next=pc+PC_INC; pc←pc+PC_INC.
- FETCH, imem_done=0:
  - if_valid=0.
  - redirect_valid latches pend_pc←redirect_pc and sets pend_valid=1; a later redirect overwrites the pending one.
  - halt→HALTED and drops the outstanding request.
- HOLD:
  - imem_en=0; the buffered instruction is presented with if_valid=1 each cycle.
  - stall=0: buffer consumed; state→FETCH.
  - redirect_valid: flush buffer; pc←redirect_pc; if_valid=0; state→FETCH. Redirect has priority over stall.
  - halt→HALTED.
- HALTED:
  - imem_en=0, if_valid=0, halted=1, pc frozen.
  - Exit only via reset. redirect/stall are ignored.
- if_valid=0 always forces if_instr=NOP_INSTR.
- Throughput with zero-wait memory and no hazards: one instruction per cycle, combinational path imem_done→if_valid.
- Latency: redirect to first new-target request is 1 cycle.
- Arithmetic: PC arithmetic is 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000 with no flag.
- Odd redirect_pc is passed through unchanged; alignment checking belongs to memory.

Decomposition:
- Shared package/header constants:
  - state encodings FETCH=2'b00, HOLD=2'b01, HALTED=2'b10;
  - NOP_INSTR and RESET_PC defaults.
- Sub-module: fetch_hold_buf, a 1-entry instruction+PC buffer with load/flush/valid, used for the HOLD state.
- The PC adder reuses the existing cla_16b.
- The PC register is a local asynchronous-reset flop. The existing synchronous register cell does not meet the reset requirement.

Test Plan:
- Zero-wait memory (imem_done tied 1), no hazards, 4 cycles after reset → if_valid=1 with pc 0000,0002,0004,0006; if_pc_next 0002..0008.
- imem_done delayed 3 cycles at pc=0004 → imem_addr=0004 held 3 cycles, if_valid=0 for those cycles, then one instruction with if_pc_next=0006.
- redirect_valid=1, redirect_pc=0040 in the cycle before a delayed imem_done → returned word discarded (if_valid=0); next imem_addr=0040.
- stall=1 for 2 cycles when instr 16'h4123 returns at pc=0008 → if_instr=4123 held 3 cycles, imem_en=0 during HOLD, next request at 000A.
- Redirect and stall asserted together in HOLD → buffer flushed, next imem_addr=redirect_pc.
- halt asserted at pc=0010 → halted=1 next cycle, imem_en=0, pc stays 0010 for 20 cycles. Asserting rst=0 asynchronously mid-cycle → pc=0000, halted=0 immediately.
